// File: rtl/ibuf_pkg.sv
// Shared constants and elaboration-time helpers for the skewed ping-pong input buffer.
package ibuf_pkg;

    localparam int unsigned N_DEF     = 4;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned DW_DEF    = 8;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Bit offset of lane k in an N-lane word; lane 0 occupies the MSB slice.
    function automatic int unsigned lane_off(input int unsigned lane,
                                             input int unsigned n_lanes,
                                             input int unsigned dw);
        return (n_lanes - 1 - lane) * dw;
    endfunction

endpackage

// File: rtl/ibuffer_lane.sv
// One lane of the ping-pong buffer: two banks of DEPTH entries, one write port
// and a registered read that outputs zero whenever the read is not valid.
module ibuffer_lane #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic          wr_bank_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_bank_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_valid_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2][DEPTH];
    logic [DW-1:0] rd_data_q;

    // Storage write; contents are not reset and only read after being written.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read, forced to zero outside the lane's valid window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_valid_i ? mem_q[rd_bank_i][rd_addr_i] : '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ibuffer_skew_pp.sv
// Double-buffered input buffer for the systolic array edge: the host fills one
// bank while the other drains with a one-cycle skew per lane.
module ibuffer_skew_pp
    import ibuf_pkg::*;
#(
    parameter  int unsigned N     = N_DEF,
    parameter  int unsigned DEPTH = DEPTH_DEF,
    parameter  int unsigned DW    = DW_DEF,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            LOAD_EN,
    input  logic [AW-1:0]   LOAD_ADDR,
    input  logic [N*DW-1:0] LOAD_WORD,
    input  logic            LOAD_LAST,
    output logic            LOAD_RDY,
    output logic            LOAD_DROP,
    input  logic            START,
    output logic            START_RDY,
    output logic            BUSY,
    output logic            DONE,
    output logic [N*DW-1:0] IROW_o,
    output logic [N-1:0]    ROW_VALID
);

    // Counter spans 0 .. DEPTH+N-2; the extra bit in CW1 holds the sign of c-k.
    localparam int unsigned    CW       = clog2(DEPTH + N);
    localparam int unsigned    CW1      = CW + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEPTH + N - 2);

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          drop_q, drop_d;
    logic [N-1:0]  row_valid_q, row_valid_d;

    logic load_rdy_c;
    logic start_rdy_c;
    logic addr_ok_c;
    logic load_acc_c;
    logic start_acc_c;

    assign load_rdy_c  = !full_q[wr_bank_q];
    assign start_rdy_c = full_q[rd_bank_q] && !busy_q;
    assign addr_ok_c   = 32'(LOAD_ADDR) < DEPTH;
    assign load_acc_c  = LOAD_EN && load_rdy_c && addr_ok_c;
    assign start_acc_c = START && start_rdy_c;

    // Next state for bank pointers, full flags, drain counter and pulses.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        drop_d    = LOAD_EN && !load_acc_c;

        if (load_acc_c && LOAD_LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end

        if (start_acc_c) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q) begin
            if (cnt_q == CNT_LAST) begin
                busy_d            = 1'b0;
                cnt_d             = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        done_d = busy_d && (cnt_d == CNT_LAST);
    end

    // Control state and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            row_valid_q <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            row_valid_q <= row_valid_d;
        end
    end

    // Lane k reads entry (c-k) of the draining bank while 0 <= c-k < DEPTH.
    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam int unsigned K   = k;
        localparam int unsigned OFF = lane_off(K, N, DW);

        logic [CW1-1:0] diff_c;
        logic           lane_v_c;
        logic [AW-1:0]  lane_addr_c;

        assign diff_c      = {1'b0, cnt_d} - CW1'(K);
        assign lane_v_c    = busy_d && !diff_c[CW1-1] && (32'(diff_c) < DEPTH);
        assign lane_addr_c = AW'(diff_c);
        assign row_valid_d[k] = lane_v_c;

        ibuffer_lane #(
            .DEPTH (DEPTH),
            .DW    (DW),
            .AW    (AW)
        ) u_lane (
            .clk_i      (CLK),
            .rst_i      (RST),
            .we_i       (load_acc_c),
            .wr_bank_i  (wr_bank_q),
            .wr_addr_i  (LOAD_ADDR),
            .wr_data_i  (LOAD_WORD[OFF +: DW]),
            .rd_bank_i  (rd_bank_q),
            .rd_addr_i  (lane_addr_c),
            .rd_valid_i (lane_v_c),
            .rd_data_o  (IROW_o[OFF +: DW])
        );
    end

    assign LOAD_RDY  = load_rdy_c;
    assign START_RDY = start_rdy_c;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign LOAD_DROP = drop_q;
    assign ROW_VALID = row_valid_q;

endmodule
